// File: rtl/schedule_read_pkg.sv
// Shared opcodes, parameter-word field widths and FSM state encoding for the
// read-direction scheduler.
package schedule_read_pkg;

  localparam logic [15:0] CMD_READ = 16'h3000;
  localparam logic [15:0] CMD_CPRD = 16'h3500;

  localparam int CHUNK_W = 16;
  localparam int FMT_W   = 12;
  localparam int CYC_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_COPR
  } state_t;

  function automatic logic [23:0] min_len(input logic [23:0] a, input logic [23:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/schedule_read.sv
// Splits one host read command into per-page NAND reads gated by read-buffer
// space, or forwards a single copyback read.
module schedule_read
  import schedule_read_pkg::*;
#(
  parameter int               PAGE_BYTES = 16384,
  parameter logic [FMT_W-1:0] PARAM_FMT  = 12'h800,
  parameter logic [CYC_W-1:0] PARAM_CYC  = 3'h6
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_cmd_ready,
  input  logic        i_cmd_valid,
  input  logic [15:0] i_rcmd_id,
  input  logic [47:0] i_raddr,
  input  logic [23:0] i_rlen,
  input  logic [15:0] i_rcmd,
  input  logic [23:0] i_rbuf_space,
  input  logic        i_page_cmd_ready,
  output logic        o_page_cmd_valid,
  output logic [15:0] o_page_cmd,
  output logic        o_page_cmd_last,
  output logic [15:0] o_page_cmd_id,
  output logic [47:0] o_page_addr,
  output logic [31:0] o_page_cmd_param,
  output logic        o_cmd_done,
  output logic        o_cmd_err
);

  localparam logic [23:0] PAGE_LEN = 24'(PAGE_BYTES);

  // Handshake: a page command moves on the rising edge where o_page_cmd_valid
  // and i_page_cmd_ready are both high; while valid is high and ready is low,
  // every o_page_* output holds its value.
  state_t r_state;
  state_t w_next;

  logic [15:0] r_id;
  logic [47:0] r_base;
  logic [23:0] r_remaining;
  logic [23:0] r_page_idx;
  logic        r_valid;
  logic [15:0] r_cmd;
  logic        r_last;
  logic [47:0] r_addr;
  logic [31:0] r_param;
  logic        r_done;
  logic        r_err;

  logic               w_accept;
  logic               w_xfer;
  logic [23:0]        w_chunk;
  logic [CHUNK_W-1:0] w_chunk_len;
  logic               w_space_ok;

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_xfer      = r_valid & i_page_cmd_ready;
  assign w_chunk     = min_len(r_remaining, PAGE_LEN);
  assign w_chunk_len = w_chunk[CHUNK_W-1:0];
  assign w_space_ok  = (i_rbuf_space >= w_chunk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i_rcmd == CMD_READ)      w_next = (i_rlen != 24'd0) ? ST_CHECK : ST_IDLE;
          else if (i_rcmd == CMD_CPRD) w_next = ST_COPR;
          else                         w_next = ST_IDLE;
        end
      end
      ST_CHECK: if (w_space_ok) w_next = ST_ISSUE;
      ST_ISSUE: if (w_xfer)     w_next = r_last ? ST_IDLE : ST_CHECK;
      ST_COPR:  if (w_xfer)     w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id        <= '0;
      r_base      <= '0;
      r_remaining <= '0;
      r_page_idx  <= '0;
      r_valid     <= 1'b0;
      r_cmd       <= '0;
      r_last      <= 1'b0;
      r_addr      <= '0;
      r_param     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id        <= i_rcmd_id;
            r_base      <= i_raddr;
            r_remaining <= i_rlen;
            r_page_idx  <= '0;
            if (i_rcmd == CMD_READ) begin
              if (i_rlen == 24'd0) r_done <= 1'b1;
            end else if (i_rcmd == CMD_CPRD) begin
              // Copyback moves no data through the buffer, so it skips the space check.
              r_valid <= 1'b1;
              r_cmd   <= CMD_CPRD;
              r_addr  <= i_raddr;
              r_param <= {{CHUNK_W{1'b0}}, PARAM_FMT, PARAM_CYC, 1'b1};
              r_last  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (w_space_ok) begin
            r_valid <= 1'b1;
            r_cmd   <= CMD_READ;
            r_addr  <= r_base + 48'(r_page_idx);
            r_param <= {w_chunk_len, PARAM_FMT, PARAM_CYC, 1'b1};
            r_last  <= (r_remaining == w_chunk);
          end
        end
        ST_ISSUE: begin
          if (w_xfer) begin
            r_valid     <= 1'b0;
            r_remaining <= r_remaining - w_chunk;
            r_page_idx  <= r_page_idx + 24'd1;
            if (r_last) r_done <= 1'b1;
          end
        end
        ST_COPR: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign o_page_cmd_valid = r_valid;
  assign o_page_cmd       = r_cmd;
  assign o_page_cmd_last  = r_last;
  assign o_page_cmd_id    = r_id;
  assign o_page_addr      = r_addr;
  assign o_page_cmd_param = r_param;
  assign o_cmd_done       = r_done;
  assign o_cmd_err        = r_err;

endmodule

// File: tb/tb_schedule_read.sv
// Directed bench for schedule_read: page splitting, buffer-space stalls,
// copyback, error/zero-length commands, reset abort and address wrap.
module tb_schedule_read;

  localparam int W = 113;

  logic        clk;
  logic        rst;
  logic        o_cmd_ready;
  logic        i_cmd_valid;
  logic [15:0] i_rcmd_id;
  logic [47:0] i_raddr;
  logic [23:0] i_rlen;
  logic [15:0] i_rcmd;
  logic [23:0] i_rbuf_space;
  logic        i_page_cmd_ready;
  logic        o_page_cmd_valid;
  logic [15:0] o_page_cmd;
  logic        o_page_cmd_last;
  logic [15:0] o_page_cmd_id;
  logic [47:0] o_page_addr;
  logic [31:0] o_page_cmd_param;
  logic        o_cmd_done;
  logic        o_cmd_err;

  schedule_read dut (
    .clk              (clk),
    .rst              (rst),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_valid      (i_cmd_valid),
    .i_rcmd_id        (i_rcmd_id),
    .i_raddr          (i_raddr),
    .i_rlen           (i_rlen),
    .i_rcmd           (i_rcmd),
    .i_rbuf_space     (i_rbuf_space),
    .i_page_cmd_ready (i_page_cmd_ready),
    .o_page_cmd_valid (o_page_cmd_valid),
    .o_page_cmd       (o_page_cmd),
    .o_page_cmd_last  (o_page_cmd_last),
    .o_page_cmd_id    (o_page_cmd_id),
    .o_page_addr      (o_page_addr),
    .o_page_cmd_param (o_page_cmd_param),
    .o_cmd_done       (o_cmd_done),
    .o_cmd_err        (o_cmd_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int n_err  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic [15:0] cmd, input logic last,
                                       input logic [15:0] id, input logic [47:0] addr,
                                       input logic [15:0] len);
    return {cmd, last, id, addr, len, 12'h800, 3'h6, 1'b1};
  endfunction

  function automatic logic [W-1:0] dut_rec();
    return {o_page_cmd, o_page_cmd_last, o_page_cmd_id, o_page_addr, o_page_cmd_param};
  endfunction

  // monitor: sampled on the falling edge, between driver updates and the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (o_page_cmd_valid && i_page_cmd_ready) got_q.push_back(dut_rec());
      if (o_cmd_done) n_done++;
      if (o_cmd_err)  n_err++;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [15:0] id, input logic [47:0] addr,
                          input logic [23:0] len, input logic [15:0] op);
    int k = 0;
    while (!o_cmd_ready && k < 50) begin tick(1); k++; end
    check("cmd_ready_before_send", o_cmd_ready, 1'b1);
    i_rcmd_id   = id;
    i_raddr     = addr;
    i_rlen      = len;
    i_rcmd      = op;
    i_cmd_valid = 1'b1;
    tick(1);
    i_cmd_valid = 1'b0;
    i_rcmd_id   = 16'($urandom);
    i_raddr     = {16'($urandom), 32'($urandom)};
    i_rlen      = 24'($urandom);
    i_rcmd      = 16'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!o_page_cmd_valid && k < 200) begin tick(1); k++; end
    check(tag, o_page_cmd_valid, 1'b1);
  endtask

  // Manual handshake: hold ready low for 'hold' cycles, then take one page.
  task automatic accept_page(input logic [W-1:0] exp, input int hold, input string tag);
    wait_valid({tag, "_valid"});
    exp_q.push_back(exp);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_stable"}, dut_rec(), exp);
      check({tag, "_held"}, o_page_cmd_valid, 1'b1);
      tick(1);
    end
    check({tag, "_rec"}, dut_rec(), exp);
    i_page_cmd_ready = 1'b1;
    tick(1);
    i_page_cmd_ready = 1'b0;
    check({tag, "_gap"}, o_page_cmd_valid, 1'b0);
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (n_done < target && k < 300) begin tick(1); k++; end
    check(tag, n_done, target);
  endtask

  // scoreboard drain
  task automatic check_pages(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_page"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_cmd_valid = 1'b0; i_rcmd_id = '0; i_raddr = '0; i_rlen = '0;
    i_rcmd = '0; i_rbuf_space = '0; i_page_cmd_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // reset state
    check("rst_ready", o_cmd_ready, 1'b1);
    check("rst_valid", o_page_cmd_valid, 1'b0);
    check("rst_cmd", o_page_cmd, 16'h0);
    check("rst_addr", o_page_addr, 48'h0);
    check("rst_param", o_page_cmd_param, 32'h0);
    check("rst_pulses", {o_cmd_done, o_cmd_err, o_page_cmd_last}, 3'b000);

    // single full page
    i_rbuf_space = 24'h010000; i_page_cmd_ready = 1'b1;
    exp_q.push_back(rec(16'h3000, 1'b1, 16'hA002, 48'h100, 16'h4000));
    send_cmd(16'hA002, 48'h100, 24'd16384, 16'h3000);
    wait_done(1, "one_page_done");
    check_pages("one_page");
    check("param_word", rec(16'h3000, 1'b1, 16'hA002, 48'h100, 16'h4000) & 113'hFFFF_FFFF, 32'h4000_800D);

    // three pages, backpressure on the second
    i_page_cmd_ready = 1'b0;
    send_cmd(16'hA003, 48'h2000, 24'd40000, 16'h3000);
    accept_page(rec(16'h3000, 1'b0, 16'hA003, 48'h2000, 16'h4000), 0, "p3_a");
    accept_page(rec(16'h3000, 1'b0, 16'hA003, 48'h2001, 16'h4000), 5, "p3_b");
    accept_page(rec(16'h3000, 1'b1, 16'hA003, 48'h2002, 16'h1C40), 0, "p3_c");
    wait_done(2, "three_page_done");
    check_pages("three_page");

    // buffer-space stall
    i_rbuf_space = 24'd10000;
    send_cmd(16'hA004, 48'h5000, 24'd20000, 16'h3000);
    tick(6);
    check("stall_no_valid", o_page_cmd_valid, 1'b0);
    i_rbuf_space = 24'd16384;
    wait_valid("stall_first_valid");
    i_rbuf_space = 24'd3000;
    accept_page(rec(16'h3000, 1'b0, 16'hA004, 48'h5000, 16'h4000), 2, "stall_a");
    tick(5);
    check("stall_second_wait", o_page_cmd_valid, 1'b0);
    i_rbuf_space = 24'd3616;
    accept_page(rec(16'h3000, 1'b1, 16'hA004, 48'h5001, 16'h0E20), 0, "stall_b");
    wait_done(3, "stall_done");
    check_pages("stall");

    // copyback with no buffer space
    i_rbuf_space = 24'd0; i_page_cmd_ready = 1'b1;
    exp_q.push_back(rec(16'h3500, 1'b1, 16'hA005, 48'h12_3456_789A, 16'h0000));
    send_cmd(16'hA005, 48'h12_3456_789A, 24'd999, 16'h3500);
    wait_done(4, "copyback_done");
    check_pages("copyback");

    // unsupported opcode, then zero-length read
    send_cmd(16'hA006, 48'h600, 24'd4096, 16'h1080);
    tick(3);
    check("bad_op_err", n_err, 1);
    check("bad_op_no_done", n_done, 4);
    send_cmd(16'hA016, 48'h610, 24'd0, 16'h3000);
    wait_done(5, "zero_len_done");
    check("zero_len_no_err", n_err, 1);
    check_pages("err_zero");

    // reset while a page command is held
    i_rbuf_space = 24'h010000; i_page_cmd_ready = 1'b0;
    send_cmd(16'hA007, 48'h700, 24'd16384, 16'h3000);
    wait_valid("rst_mid_valid");
    rst = 1'b1;
    #1;
    check("rst_mid_valid_low", o_page_cmd_valid, 1'b0);
    tick(1);
    rst = 1'b0;
    #1;
    check("rst_mid_ready", o_cmd_ready, 1'b1);
    tick(4);
    check("rst_mid_abandoned", o_page_cmd_valid, 1'b0);
    check("rst_mid_no_done", n_done, 5);
    check_pages("rst_mid");

    // address wrap across the 48-bit boundary
    i_page_cmd_ready = 1'b1;
    exp_q.push_back(rec(16'h3000, 1'b0, 16'hA008, 48'hFFFF_FFFF_FFFF, 16'h4000));
    exp_q.push_back(rec(16'h3000, 1'b1, 16'hA008, 48'h0, 16'h0E20));
    send_cmd(16'hA008, 48'hFFFF_FFFF_FFFF, 24'd20000, 16'h3000);
    wait_done(6, "wrap_done");
    check_pages("wrap");
    check("final_err_count", n_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
